max7219_frame_driver: RTL
=========================

Name: max7219_frame_driver

Overview:
- Serial front end for the 8-digit MAX7219 display on the PCB. It sits directly downstream of the eight segment encoders (c0..c7 rotor/ring/number characters) and drives the GPIO DIN/CLK/CS pins.
- After reset it sends the MAX7219 configuration sequence.
- It then rewrites all eight digit registers whenever the segment data changes or a refresh is requested.
- It replaces free-running continuous shifting with an explicit frame FSM, a busy/done status and a pending-request latch.

Parameters:
- CLK_DIV, 2, clk cycles per max_clk half-period (legal range ≥1; bit time = 2*CLK_DIV).
- INTENSITY, 4'h8, value written to the intensity register (0x0A).
- SCAN_LIMIT, 3'd7, value written to the scan-limit register (0x0B).

Ports:
- clk  in  1  system clock (CLOCK_50 domain, or the divided display clock)
- rst_l  in  1  asynchronous active-low reset
- digits  in  64  segment bytes {c7,c6,c5,c4,c3,c2,c1,c0}; bit 7 of each byte = DP
- update  in  1  single-cycle refresh request
- busy  out  1  high while any frame is in flight or queued
- init_done  out  1  high once the configuration sequence is complete
- max_din  out  1  serial data to MAX7219 DIN
- max_clk  out  1  serial clock to MAX7219 CLK
- max_cs  out  1  load/chip-select, active-low

Behaviour:
- Reset (async, rst_l=0):
  - max_cs=1, max_clk=0, max_din=0, busy=1, init_done=0.
  - FSM=INIT, init index=0, refresh_pending=1, snapshot=0.
  - Assertion mid-frame aborts immediately; no partial-frame recovery. The sequence restarts from the first init frame after release.
- Frame format: 16 bits, MSB first, {addr[7:0], data[7:0]}.
- Frame timing, total 35*CLK_DIV cycles:
  - The first cycle of LOAD drives max_cs=0, max_clk=0 and max_din=bit15.
  - Per bit: max_clk=0 for CLK_DIV cycles with max_din stable, then max_clk=1 for CLK_DIV cycles. max_din changes only on the cycle max_clk falls.
  - After bit 0's high phase: max_clk=0 and max_cs held low for CLK_DIV cycles (HOLD).
  - Then max_cs=1 for 2*CLK_DIV cycles (GAP) before any next frame.
- States: INIT, IDLE, LOAD, SHIFT, HOLD, GAP.
  - INIT sends five frames in order: 0x0C01 (shutdown off), 0x0900 (no decode), 0x0B00|SCAN_LIMIT, 0x0A00|INTENSITY, 0x0F00 (test off).
  - init_done rises on the cycle the GAP of frame 5 ends and stays high until reset.
- Refresh:
  - Entered from IDLE when (update | refresh_pending | digits != snapshot).
  - On entry: snapshot<=digits, refresh_pending<=0.
  - Eight frames are sent: addr 0x01..0x08, data = snapshot byte (addr N carries digits[8N-1:8N-8]).
  - The first refresh runs automatically after init.
- Simultaneous events:
  - update asserted while busy sets refresh_pending; it is serviced after the current refresh.
  - Multiple updates during one refresh collapse into one.
  - digits changing mid-refresh does not alter the in-flight frames, which use the snapshot. The mismatch triggers exactly one further refresh.
  - update ignored during INIT is still latched as pending.
- busy: low only in IDLE with no trigger condition true.
- Counters:
  - bit counter 4 bits, wraps 15→0 only at frame end.
  - frame index 3 bits.
  - divider counter sized $clog2(2*CLK_DIV)+1. No overflow is permitted across the legal range.
- Outputs are registered (no combinational path from digits/update to pins).

Test Plan:
- Reset release, CLK_DIV=2, digits=0 → frames 0x0C01, 0x0900, 0x0B07, 0x0A08, 0x0F00, then 0x0100..0x0800.
  - Each frame spans 70 cycles of clk; max_cs low for exactly 66 cycles per frame.
  - init_done rises at cycle 350; busy falls at cycle 910.
- Idle with digits stable, no update for 2000 cycles → max_cs stays 1, busy=0, no max_clk edges.
- From idle, set digits byte c3=0x77 → one 8-frame refresh; frame 4 = 0x0477. Decode DIN sampled on max_clk rising edges; all 16-bit words must match.
- Pulse update three times during a refresh → exactly one extra refresh follows, which starts after the current GAP. busy stays high continuously.
- Change c0 from 0x30 to 0x6D during frame 2 of a refresh → in-flight frame 1 carries 0x30; a second refresh follows with 0x016D.
- Assert rst_l low mid-bit of a digit frame → same-cycle max_cs=1, max_clk=0, init_done=0. After release the init sequence restarts with 0x0C01.

Source files
------------

// File: rtl/max7219_frame_driver.sv
// max7219_frame_driver: MAX7219 serial front end with power-up configuration and change-triggered digit refresh
module max7219_frame_driver #(
  parameter int         CLK_DIV    = 2,
  parameter logic [3:0] INTENSITY  = 4'h8,
  parameter logic [2:0] SCAN_LIMIT = 3'd7
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic [63:0] digits,
  input  logic        update,
  output logic        busy,
  output logic        init_done,
  output logic        max_din,
  output logic        max_clk,
  output logic        max_cs
);
  localparam int DW = $clog2(2 * CLK_DIV) + 1;
  localparam logic [DW-1:0] HALF     = DW'(CLK_DIV);
  localparam logic [DW-1:0] HALF_TOP = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] BIT_TOP  = DW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {INIT, IDLE, LOAD, SHIFT, HOLD, GAP} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [2:0]    frm_q, frm_d;
  logic [15:0]   sr_q, sr_d;
  logic [63:0]   snap_q, snap_d;
  logic          pend_q, pend_d;
  logic          clk_q, clk_d;
  logic          cs_q, cs_d;
  logic          busy_q, busy_d;
  logic          init_done_q, init_done_d;
  logic          trig, load, word_ini;

  function automatic logic [15:0] frame_word(input logic ini, input logic [2:0] idx, input logic [63:0] s);
    if (!ini) return {8'(idx) + 8'd1, s[{idx, 3'b000} +: 8]};
    return idx == 3'd0 ? 16'h0C01 :
           idx == 3'd1 ? 16'h0900 :
           idx == 3'd2 ? {8'h0B, 5'd0, SCAN_LIMIT} :
           idx == 3'd3 ? {8'h0A, 4'd0, INTENSITY} : 16'h0F00;
  endfunction

  assign trig      = update | pend_q | (digits != snap_q);
  assign max_din   = sr_q[15];
  assign max_clk   = clk_q;
  assign max_cs    = cs_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;

  // Frame sequencer: bit timing, frame selection and refresh triggering
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    frm_d       = frm_q;
    sr_d        = sr_q;
    snap_d      = snap_q;
    pend_d      = pend_q | update;
    clk_d       = 1'b0;
    cs_d        = 1'b1;
    init_done_d = init_done_q;
    load        = 1'b0;
    word_ini    = !init_done_q;
    case (state_q)
      INIT: begin
        load  = 1'b1;
        frm_d = 3'd0;
      end
      IDLE: if (trig) begin
        load   = 1'b1;
        frm_d  = 3'd0;
        snap_d = digits;
        pend_d = 1'b0;
      end
      LOAD, SHIFT: begin
        cs_d = 1'b0;
        if (cnt_q == BIT_TOP) begin
          cnt_d   = '0;
          sr_d    = sr_q << 1;
          bit_d   = bit_q + 4'd1;
          state_d = bit_q == 4'd15 ? HOLD : SHIFT;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = SHIFT;
          clk_d   = cnt_d >= HALF;
        end
      end
      HOLD: if (cnt_q == HALF_TOP) begin
        state_d = GAP;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        cs_d  = 1'b0;
      end
      GAP: if (cnt_q == BIT_TOP) begin
        cnt_d = '0;
        if (!init_done_q && frm_q == 3'd4) begin
          init_done_d = 1'b1;
          word_ini    = 1'b0;
          load        = 1'b1;
          frm_d       = 3'd0;
          snap_d      = digits;
          pend_d      = 1'b0;
        end else if (init_done_q && frm_q == 3'd7) begin
          state_d = IDLE;
        end else begin
          load  = 1'b1;
          frm_d = frm_q + 3'd1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = INIT;
    endcase
    if (load) begin
      state_d = LOAD;
      cnt_d   = '0;
      bit_d   = 4'd0;
      cs_d    = 1'b0;
      clk_d   = 1'b0;
      sr_d    = frame_word(word_ini, frm_d, snap_d);
    end
    busy_d = (state_d != IDLE) | pend_d | (digits != snap_d);
  end

  // State and registered pin drivers; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      bit_q       <= 4'd0;
      frm_q       <= 3'd0;
      sr_q        <= 16'd0;
      snap_q      <= 64'd0;
      pend_q      <= 1'b1;
      clk_q       <= 1'b0;
      cs_q        <= 1'b1;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      frm_q       <= frm_d;
      sr_q        <= sr_d;
      snap_q      <= snap_d;
      pend_q      <= pend_d;
      clk_q       <= clk_d;
      cs_q        <= cs_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
    end
  end
endmodule
